cache_repl_policy: RTL and testbench
====================================

Name: cache_repl_policy

Overview:
- Parametrised cache replacement-policy unit for the I$ and D$.
- Generalises the current fixed tree-PLRU into a selectable policy: tree pseudo-LRU, per-set round-robin, or LFSR random.
- Works for any power-of-two way and set count.
- Sits beside each cache's tag/data arrays; the cache FSM supplies set index, hit/valid vectors and a write strobe, and receives a one-hot victim way.

Parameters:
- NUMWAYS, 4, associativity; power of two, 2..16.
- NUMSETS, 64, number of sets; power of two.
- SETLEN, $clog2(NUMSETS), set index width.
- POLICY, 0, replacement policy: 0 = tree PLRU, 1 = round-robin, 2 = LFSR random.

Ports:
- clk  input  1  core clock.
- reset  input  1  synchronous, active-high reset.
- CacheEn  input  1  stage enable; SetIdx is captured when high.
- FlushStage  input  1  suppresses state updates this cycle.
- SetIdx  input  SETLEN  set being looked up.
- ValidWay  input  NUMWAYS  valid bits of the addressed set.
- HitWay  input  NUMWAYS  one-hot hit vector; all zero means miss.
- LRUWriteEn  input  1  commit an access/fill to replacement state.
- InvalidateCache  input  1  clear all replacement state.
- VictimWay  output  NUMWAYS  one-hot way to replace.

Behaviour:
- Interface:
  - One clock, clk.
  - Reset is synchronous and active-high, named reset.
  - All state changes occur on the rising edge of clk.
- Set register:
  - SetIdxQ <= SetIdx when CacheEn.
  - Reset value 0.
  - All reads and updates use SetIdxQ.
- Victim selection (combinational from state[SetIdxQ]):
  - If any ValidWay bit is 0, VictimWay = lowest-index invalid way.
  - Otherwise VictimWay comes from the policy.
  - VictimWay is always exactly one-hot.
- PLRU, POLICY=0:
  - NUMWAYS-1 tree bits per set; node bit 1 = victim in upper half.
  - Walk from the root to a leaf to pick the victim.
  - On update, set every node on the path of UsedWay to point away from UsedWay.
- Round-robin, POLICY=1:
  - $clog2(NUMWAYS)-bit counter per set; victim = counter.
  - Counter increments only on a fill.
  - Counter wraps NUMWAYS-1 -> 0.
  - Hits do not change the counter.
- Random, POLICY=2:
  - One global 8-bit Fibonacci LFSR, taps x^8+x^6+x^5+x^4+1, seed 8'h01.
  - Advances every cycle CacheEn=1.
  - Victim = low $clog2(NUMWAYS) bits.
  - The LFSR never reaches 0.
- Update:
  - Occurs when LRUWriteEn & ~FlushStage.
  - UsedWay = |HitWay ? HitWay : VictimWay.
  - Fill = ~|HitWay.
  - Write state[SetIdxQ].
  - The new state is visible to the lookup in the next cycle.
- InvalidateCache: all per-set state cleared to 0 at the next edge. It has priority over a same-cycle LRUWriteEn.
- Reset:
  - All per-set state = 0; SetIdxQ = 0; LFSR = 8'h01.
  - With ValidWay=0 after reset, VictimWay = 'b0001.
- FlushStage:
  - Blocks updates only; the victim output is unaffected.
  - SetIdxQ still follows CacheEn.
- Reset asserted mid-operation discards any pending update in that cycle.
- Illegal inputs:
  - HitWay with more than one bit set is illegal; a simulation assertion fires.
  - Behaviour is undefined.

Optional Feature:
- Macro: CACHE_WAY_LOCK_EN.
- When defined:
  - Extra input port WayLockMask [NUMWAYS-1:0]; locked ways are never chosen as victim.
  - If the policy or invalid-way choice is locked, VictimWay = lowest-index unlocked way, preferring invalid unlocked ways.
  - If all ways are locked, the mask is ignored.
  - Hits to locked ways still update PLRU state.
- When undefined: no port, no lock logic.

Test Plan:
- PLRU, NUMWAYS=4:
  - After reset, all valid, set 5 -> VictimWay=0001.
  - Hit way0 + LRUWriteEn -> next cycle VictimWay=0100.
  - Hit way2 + LRUWriteEn -> VictimWay=0010.
- Invalid preference: ValidWay=1011, any state -> VictimWay=0100. ValidWay=0000 -> 0001.
- Round-robin, all valid, set 3:
  - Four fills -> victims 0001, 0010, 0100, 1000, then wrap to 0001.
  - Interleaved hits do not advance the counter.
  - Set 4 is unaffected.
- FlushStage=1 with LRUWriteEn=1 (hit way0, PLRU) -> state unchanged; VictimWay stays 0001.
- InvalidateCache and LRUWriteEn in the same cycle after several PLRU updates -> all sets return to victim 0001.
- CACHE_WAY_LOCK_EN, PLRU reset state:
  - WayLockMask=0001, all valid -> VictimWay=0010.
  - WayLockMask=1111 -> VictimWay=0001 (mask ignored).

Source files
------------

// File: rtl/cache_repl_policy.sv
// Replacement-policy unit for a set-associative cache: tree PLRU, round-robin or LFSR victim choice.
// Optional way locking is compiled in with `define CACHE_WAY_LOCK_EN (adds the WayLockMask port).
module cache_repl_policy #(
  parameter int NUMWAYS = 4,
  parameter int NUMSETS = 64,
  parameter int SETLEN  = $clog2(NUMSETS),
  parameter int POLICY  = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               CacheEn,
  input  logic               FlushStage,
  input  logic [SETLEN-1:0]  SetIdx,
  input  logic [NUMWAYS-1:0] ValidWay,
  input  logic [NUMWAYS-1:0] HitWay,
  input  logic               LRUWriteEn,
  input  logic               InvalidateCache,
`ifdef CACHE_WAY_LOCK_EN
  input  logic [NUMWAYS-1:0] WayLockMask,
`endif
  output logic [NUMWAYS-1:0] VictimWay
);

  localparam int WAYLEN = $clog2(NUMWAYS);
  localparam int NODEW  = WAYLEN + 1;

  logic [SETLEN-1:0]  set_q;
  logic [NUMWAYS-1:0] policy_way;
  logic [NUMWAYS-1:0] base_way;
  logic               update;

  function automatic logic [NUMWAYS-1:0] lowest_one(input logic [NUMWAYS-1:0] v);
    return v & (~v + NUMWAYS'(1));
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      set_q <= '0;
    end else if (CacheEn) begin
      set_q <= SetIdx;
    end
  end

  assign update   = LRUWriteEn & ~FlushStage;
  assign base_way = (|(~ValidWay)) ? lowest_one(~ValidWay) : policy_way;

`ifdef CACHE_WAY_LOCK_EN
  logic [NUMWAYS-1:0] lock_eff;

  // A fully locked set behaves as if nothing were locked, so a victim always exists.
  always_comb begin
    lock_eff  = (&WayLockMask) ? '0 : WayLockMask;
    VictimWay = base_way;
    if (|(base_way & lock_eff)) begin
      if (|(~ValidWay & ~lock_eff)) begin
        VictimWay = lowest_one(~ValidWay & ~lock_eff);
      end else begin
        VictimWay = lowest_one(~lock_eff);
      end
    end
  end
`else
  assign VictimWay = base_way;
`endif

  generate
    if (POLICY == 0) begin : g_plru
      // Heap-ordered tree: node n has children 2n and 2n+1; leaves NUMWAYS..2*NUMWAYS-1 are ways.
      logic [NUMWAYS-1:1] tree_mem [NUMSETS];
      logic [NUMWAYS-1:1] tree_cur;
      logic [NUMWAYS-1:1] tree_nxt;
      logic [NUMWAYS-1:0] used_way;
      logic [WAYLEN-1:0]  used_idx;
      logic [NODEW-1:0]   node;
      logic [NODEW-1:0]   path;
      logic               pick;
      logic               dir;

      assign tree_cur = tree_mem[set_q];
      assign used_way = (|HitWay) ? HitWay : VictimWay;

      always_comb begin
        node = NODEW'(1);
        pick = 1'b0;
        for (int l = 0; l < WAYLEN; l++) begin
          pick = 1'b0;
          for (int n = 1; n < NUMWAYS; n++) begin
            if (node == NODEW'(n)) pick = tree_cur[n];
          end
          node = {node[WAYLEN-1:0], pick};
        end
        policy_way = NUMWAYS'(1) << node[WAYLEN-1:0];
      end

      // Climb from the used leaf to the root, pointing each ancestor at the other subtree.
      always_comb begin
        used_idx = '0;
        for (int w = 0; w < NUMWAYS; w++) begin
          if (used_way[w]) used_idx = WAYLEN'(w);
        end
        tree_nxt = tree_cur;
        path     = {1'b1, used_idx};
        dir      = 1'b0;
        for (int l = 0; l < WAYLEN; l++) begin
          dir  = path[0];
          path = path >> 1;
          for (int n = 1; n < NUMWAYS; n++) begin
            if (path == NODEW'(n)) tree_nxt[n] = ~dir;
          end
        end
      end

      always_ff @(posedge clk) begin
        if (reset || InvalidateCache) begin
          for (int s = 0; s < NUMSETS; s++) tree_mem[s] <= '0;
        end else if (update) begin
          tree_mem[set_q] <= tree_nxt;
        end
      end
    end else if (POLICY == 1) begin : g_rr
      logic [WAYLEN-1:0] rr_mem [NUMSETS];

      assign policy_way = NUMWAYS'(1) << rr_mem[set_q];

      // Only fills advance the pointer; power-of-two way count makes the wrap free.
      always_ff @(posedge clk) begin
        if (reset || InvalidateCache) begin
          for (int s = 0; s < NUMSETS; s++) rr_mem[s] <= '0;
        end else if (update && !(|HitWay)) begin
          rr_mem[set_q] <= rr_mem[set_q] + WAYLEN'(1);
        end
      end
    end else begin : g_lfsr
      logic [7:0] lfsr;

      assign policy_way = NUMWAYS'(1) << lfsr[WAYLEN-1:0];

      // x^8+x^6+x^5+x^4+1 is primitive, so a nonzero seed never reaches the all-zero state.
      always_ff @(posedge clk) begin
        if (reset) begin
          lfsr <= 8'h01;
        end else if (CacheEn) begin
          lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
      end
    end
  endgenerate

  hit_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(HitWay));

endmodule

// File: tb/tb_cache_repl_policy.sv
// Self-checking bench for cache_repl_policy: one instance per policy sharing the same stimulus,
// directed scenarios followed by randomized traffic against a behavioural model.
module tb_cache_repl_policy;

  localparam int NUMWAYS = 4;
  localparam int NUMSETS = 64;
  localparam int SETLEN  = $clog2(NUMSETS);

  logic              clk = 1'b0;
  logic              reset;
  logic              cache_en;
  logic              flush_stage;
  logic [SETLEN-1:0] set_idx;
  logic [3:0]        valid_way;
  logic [3:0]        hit_way;
  logic              lru_write_en;
  logic              invalidate_cache;
  logic [3:0]        way_lock_mask;
  logic [3:0]        victim_plru;
  logic [3:0]        victim_rr;
  logic [3:0]        victim_rnd;

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  bit         plru_m [NUMSETS][NUMWAYS];
  int         rr_m   [NUMSETS];
  logic [7:0] lfsr_m;
  int         setq_m;

  always #5 clk = ~clk;

  cache_repl_policy #(.NUMWAYS(NUMWAYS), .NUMSETS(NUMSETS), .POLICY(0)) dut_plru (
    .clk(clk), .reset(reset), .CacheEn(cache_en), .FlushStage(flush_stage),
    .SetIdx(set_idx), .ValidWay(valid_way), .HitWay(hit_way),
    .LRUWriteEn(lru_write_en), .InvalidateCache(invalidate_cache),
`ifdef CACHE_WAY_LOCK_EN
    .WayLockMask(way_lock_mask),
`endif
    .VictimWay(victim_plru));

  cache_repl_policy #(.NUMWAYS(NUMWAYS), .NUMSETS(NUMSETS), .POLICY(1)) dut_rr (
    .clk(clk), .reset(reset), .CacheEn(cache_en), .FlushStage(flush_stage),
    .SetIdx(set_idx), .ValidWay(valid_way), .HitWay(hit_way),
    .LRUWriteEn(lru_write_en), .InvalidateCache(invalidate_cache),
`ifdef CACHE_WAY_LOCK_EN
    .WayLockMask(way_lock_mask),
`endif
    .VictimWay(victim_rr));

  cache_repl_policy #(.NUMWAYS(NUMWAYS), .NUMSETS(NUMSETS), .POLICY(2)) dut_rnd (
    .clk(clk), .reset(reset), .CacheEn(cache_en), .FlushStage(flush_stage),
    .SetIdx(set_idx), .ValidWay(valid_way), .HitWay(hit_way),
    .LRUWriteEn(lru_write_en), .InvalidateCache(invalidate_cache),
`ifdef CACHE_WAY_LOCK_EN
    .WayLockMask(way_lock_mask),
`endif
    .VictimWay(victim_rnd));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic defaults();
    reset            = 1'b0;
    cache_en         = 1'b0;
    flush_stage      = 1'b0;
    valid_way        = 4'hF;
    hit_way          = 4'h0;
    lru_write_en     = 1'b0;
    invalidate_cache = 1'b0;
  endtask

  task automatic select_set(input int s);
    set_idx  = SETLEN'(s);
    cache_en = 1'b1;
    tick();
    cache_en = 1'b0;
  endtask

  // Tree PLRU seen as repeated halving of the way range.
  function automatic int plru_pick(input int s);
    int node = 1;
    int lo = 0;
    int size = NUMWAYS;
    while (size > 1) begin
      size = size / 2;
      if (plru_m[s][node]) begin
        lo += size;
        node = 2 * node + 1;
      end else begin
        node = 2 * node;
      end
    end
    return lo;
  endfunction

  function automatic void plru_touch(input int s, input int w);
    int node = 1;
    int lo = 0;
    int size = NUMWAYS;
    while (size > 1) begin
      size = size / 2;
      if (w >= lo + size) begin
        plru_m[s][node] = 1'b0;
        lo += size;
        node = 2 * node + 1;
      end else begin
        plru_m[s][node] = 1'b1;
        node = 2 * node;
      end
    end
  endfunction

  function automatic logic [3:0] choose(input logic [3:0] valid, input int pol_idx, input logic [3:0] mask);
    logic [3:0] eff;
    int cand;
    eff  = (mask == 4'hF) ? 4'h0 : mask;
    cand = pol_idx;
    for (int w = NUMWAYS - 1; w >= 0; w--) if (!valid[w]) cand = w;
    if (eff[cand[1:0]]) begin
      cand = -1;
      for (int w = NUMWAYS - 1; w >= 0; w--) if (!valid[w] && !eff[w]) cand = w;
      if (cand < 0) begin
        for (int w = NUMWAYS - 1; w >= 0; w--) if (!eff[w]) cand = w;
      end
    end
    return 4'(1 << cand);
  endfunction

  function automatic void model_reset();
    for (int s = 0; s < NUMSETS; s++) begin
      rr_m[s] = 0;
      for (int n = 0; n < NUMWAYS; n++) plru_m[s][n] = 1'b0;
    end
    setq_m = 0;
    lfsr_m = 8'h01;
  endfunction

  task automatic test_reset();
    reset = 1'b1; cache_en = 1'b1; set_idx = 9; lru_write_en = 1'b1; hit_way = 4'h0;
    tick();
    tick();
    defaults();
    valid_way = 4'h0;
    #2;
    checks++; if (victim_plru !== 4'b0001) begin errors++; $display("[TB] FAIL reset_invalid_plru: got %b expected 0001", victim_plru); end
    checks++; if (victim_rr !== 4'b0001) begin errors++; $display("[TB] FAIL reset_invalid_rr: got %b expected 0001", victim_rr); end
    checks++; if (victim_rnd !== 4'b0001) begin errors++; $display("[TB] FAIL reset_invalid_rnd: got %b expected 0001", victim_rnd); end
    valid_way = 4'hF;
    #2;
    checks++; if (victim_plru !== 4'b0001) begin errors++; $display("[TB] FAIL reset_plru: got %b expected 0001", victim_plru); end
    checks++; if (victim_rr !== 4'b0001) begin errors++; $display("[TB] FAIL reset_rr: got %b expected 0001", victim_rr); end
    checks++; if (victim_rnd !== 4'b0010) begin errors++; $display("[TB] FAIL reset_rnd: got %b expected 0010", victim_rnd); end
  endtask

  task automatic test_plru();
    select_set(5);
    #2;
    checks++; if (victim_plru !== 4'b0001) begin errors++; $display("[TB] FAIL plru_initial: got %b expected 0001", victim_plru); end
    hit_way = 4'b0001; lru_write_en = 1'b1;
    tick();
    defaults();
    #2;
    checks++; if (victim_plru !== 4'b0100) begin errors++; $display("[TB] FAIL plru_hit_way0: got %b expected 0100", victim_plru); end
    checks++; if (victim_rr !== 4'b0001) begin errors++; $display("[TB] FAIL rr_hit_no_advance: got %b expected 0001", victim_rr); end
    hit_way = 4'b0100; lru_write_en = 1'b1;
    tick();
    defaults();
    #2;
    checks++; if (victim_plru !== 4'b0010) begin errors++; $display("[TB] FAIL plru_hit_way2: got %b expected 0010", victim_plru); end
  endtask

  task automatic test_invalid_pref();
    valid_way = 4'b1011;
    #2;
    checks++; if (victim_plru !== 4'b0100) begin errors++; $display("[TB] FAIL invalid_pref_plru: got %b expected 0100", victim_plru); end
    checks++; if (victim_rr !== 4'b0100) begin errors++; $display("[TB] FAIL invalid_pref_rr: got %b expected 0100", victim_rr); end
    checks++; if (victim_rnd !== 4'b0100) begin errors++; $display("[TB] FAIL invalid_pref_rnd: got %b expected 0100", victim_rnd); end
    valid_way = 4'b0000;
    #2;
    checks++; if (victim_plru !== 4'b0001) begin errors++; $display("[TB] FAIL none_valid_plru: got %b expected 0001", victim_plru); end
    checks++; if (victim_rr !== 4'b0001) begin errors++; $display("[TB] FAIL none_valid_rr: got %b expected 0001", victim_rr); end
    defaults();
  endtask

  task automatic test_round_robin();
    logic [3:0] exp;
    select_set(3);
    for (int i = 0; i < 5; i++) begin
      exp = 4'(1 << (i % NUMWAYS));
      #2;
      checks++; if (victim_rr !== exp) begin errors++; $display("[TB] FAIL rr_fill_%0d: got %b expected %b", i, victim_rr, exp); end
      lru_write_en = 1'b1; hit_way = 4'h0;
      tick();
      defaults();
    end
    hit_way = 4'b1000; lru_write_en = 1'b1;
    tick();
    defaults();
    #2;
    checks++; if (victim_rr !== 4'b0010) begin errors++; $display("[TB] FAIL rr_hit_interleaved: got %b expected 0010", victim_rr); end
    select_set(4);
    #2;
    checks++; if (victim_rr !== 4'b0001) begin errors++; $display("[TB] FAIL rr_other_set: got %b expected 0001", victim_rr); end
    select_set(3);
    #2;
    checks++; if (victim_rr !== 4'b0010) begin errors++; $display("[TB] FAIL rr_set3_kept: got %b expected 0010", victim_rr); end
  endtask

  task automatic test_flush();
    select_set(7);
    flush_stage = 1'b1; hit_way = 4'b0001; lru_write_en = 1'b1;
    #2;
    checks++; if (victim_plru !== 4'b0001) begin errors++; $display("[TB] FAIL flush_victim_live: got %b expected 0001", victim_plru); end
    tick();
    defaults();
    #2;
    checks++; if (victim_plru !== 4'b0001) begin errors++; $display("[TB] FAIL flush_plru_held: got %b expected 0001", victim_plru); end
    flush_stage = 1'b1; hit_way = 4'h0; lru_write_en = 1'b1; set_idx = 3; cache_en = 1'b1;
    tick();
    defaults();
    #2;
    checks++; if (victim_rr !== 4'b0010) begin errors++; $display("[TB] FAIL flush_setidx_follows: got %b expected 0010", victim_rr); end
    select_set(7);
    #2;
    checks++; if (victim_rr !== 4'b0001) begin errors++; $display("[TB] FAIL flush_rr_held: got %b expected 0001", victim_rr); end
  endtask

  task automatic test_invalidate();
    select_set(1);
    lru_write_en = 1'b1;
    tick();
    tick();
    defaults();
    #2;
    checks++; if (victim_rr !== 4'b0100) begin errors++; $display("[TB] FAIL inval_pre_rr: got %b expected 0100", victim_rr); end
    checks++; if (victim_plru !== 4'b0010) begin errors++; $display("[TB] FAIL inval_pre_plru: got %b expected 0010", victim_plru); end
    select_set(2);
    hit_way = 4'b0010; lru_write_en = 1'b1;
    tick();
    defaults();
    #2;
    checks++; if (victim_plru !== 4'b0100) begin errors++; $display("[TB] FAIL inval_pre_plru2: got %b expected 0100", victim_plru); end
    invalidate_cache = 1'b1; hit_way = 4'b0010; lru_write_en = 1'b1;
    tick();
    defaults();
    #2;
    checks++; if (victim_plru !== 4'b0001) begin errors++; $display("[TB] FAIL inval_priority_plru: got %b expected 0001", victim_plru); end
    select_set(1);
    #2;
    checks++; if (victim_plru !== 4'b0001) begin errors++; $display("[TB] FAIL inval_set1_plru: got %b expected 0001", victim_plru); end
    checks++; if (victim_rr !== 4'b0001) begin errors++; $display("[TB] FAIL inval_set1_rr: got %b expected 0001", victim_rr); end
    select_set(5);
    #2;
    checks++; if (victim_plru !== 4'b0001) begin errors++; $display("[TB] FAIL inval_set5_plru: got %b expected 0001", victim_plru); end
  endtask

  task automatic test_mid_reset();
    select_set(6);
    hit_way = 4'b0001; lru_write_en = 1'b1;
    tick();
    defaults();
    #2;
    checks++; if (victim_plru !== 4'b0100) begin errors++; $display("[TB] FAIL midreset_pre: got %b expected 0100", victim_plru); end
    reset = 1'b1; hit_way = 4'h0; lru_write_en = 1'b1;
    tick();
    defaults();
    select_set(6);
    #2;
    checks++; if (victim_plru !== 4'b0001) begin errors++; $display("[TB] FAIL midreset_plru: got %b expected 0001", victim_plru); end
    checks++; if (victim_rr !== 4'b0001) begin errors++; $display("[TB] FAIL midreset_rr: got %b expected 0001", victim_rr); end
  endtask

`ifdef CACHE_WAY_LOCK_EN
  task automatic test_way_lock();
    reset = 1'b1;
    tick();
    defaults();
    way_lock_mask = 4'b0001;
    #2;
    checks++; if (victim_plru !== 4'b0010) begin errors++; $display("[TB] FAIL lock_way0: got %b expected 0010", victim_plru); end
    way_lock_mask = 4'b1111;
    #2;
    checks++; if (victim_plru !== 4'b0001) begin errors++; $display("[TB] FAIL lock_all_ignored: got %b expected 0001", victim_plru); end
    way_lock_mask = 4'b0001; valid_way = 4'b1010;
    #2;
    checks++; if (victim_plru !== 4'b0100) begin errors++; $display("[TB] FAIL lock_invalid_pref: got %b expected 0100", victim_plru); end
    way_lock_mask = 4'h0;
    defaults();
  endtask
`endif

  task automatic test_random();
    logic [3:0] exp_p, exp_r, exp_n;
    int k;
    reset = 1'b1;
    tick();
    defaults();
    model_reset();
    for (int i = 0; i < 1500; i++) begin
      cache_en         = 1'($urandom_range(0, 1));
      set_idx          = SETLEN'($urandom_range(0, 7));
      valid_way        = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      k                = $urandom_range(0, NUMWAYS);
      hit_way          = (k == NUMWAYS) ? 4'h0 : 4'(1 << k);
      lru_write_en     = 1'($urandom_range(0, 1));
      flush_stage      = ($urandom_range(0, 3) == 0);
      invalidate_cache = ($urandom_range(0, 40) == 0);
`ifdef CACHE_WAY_LOCK_EN
      way_lock_mask    = 4'($urandom);
`endif
      #2;
      exp_p = choose(valid_way, plru_pick(setq_m), way_lock_mask);
      exp_r = choose(valid_way, rr_m[setq_m], way_lock_mask);
      exp_n = choose(valid_way, int'(lfsr_m[1:0]), way_lock_mask);
      checks++; if (victim_plru !== exp_p) begin errors++; $display("[TB] FAIL rand_plru cycle %0d: got %b expected %b", i, victim_plru, exp_p); end
      checks++; if (victim_rr !== exp_r) begin errors++; $display("[TB] FAIL rand_rr cycle %0d: got %b expected %b", i, victim_rr, exp_r); end
      checks++; if (victim_rnd !== exp_n) begin errors++; $display("[TB] FAIL rand_rnd cycle %0d: got %b expected %b", i, victim_rnd, exp_n); end
      if (invalidate_cache) begin
        for (int s = 0; s < NUMSETS; s++) begin
          rr_m[s] = 0;
          for (int n = 0; n < NUMWAYS; n++) plru_m[s][n] = 1'b0;
        end
      end else if (lru_write_en && !flush_stage) begin
        plru_touch(setq_m, (hit_way != 4'h0) ? $clog2(hit_way) : $clog2(exp_p));
        if (hit_way == 4'h0) rr_m[setq_m] = (rr_m[setq_m] + 1) % NUMWAYS;
      end
      if (cache_en) begin
        setq_m = int'(set_idx);
        lfsr_m = {lfsr_m[6:0], ^(lfsr_m & 8'hB8)};
      end
      tick();
    end
    defaults();
    way_lock_mask = 4'h0;
  endtask

  initial begin
    defaults();
    set_idx       = '0;
    way_lock_mask = 4'h0;
    tick();
    test_reset();
    test_plru();
    test_invalid_pref();
    test_round_robin();
    test_flush();
    test_invalidate();
    test_mid_reset();
`ifdef CACHE_WAY_LOCK_EN
    test_way_lock();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
